// File: rtl/dmem_loader_pkg.sv
// Shared definitions for the data-memory loader: FSM states and memory-image
// layout helpers, used by the RTL and by anything that locates operands/results.
package dmem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_START,
    ST_DONE
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Matrix shape the matrix-multiply program is built for.
  localparam int unsigned DEF_M  = 3;
  localparam int unsigned DEF_N  = 4;
  localparam int unsigned DEF_N2 = 1;

  function automatic int unsigned calc_load_bytes(input int unsigned m,
                                                  input int unsigned n,
                                                  input int unsigned n2);
    return BYTES_PER_WORD * (m * n + n * n2);
  endfunction

  function automatic int unsigned calc_res_words(input int unsigned m,
                                                 input int unsigned n2);
    return m * n2;
  endfunction

  localparam int unsigned LOAD_BYTES = calc_load_bytes(DEF_M, DEF_N, DEF_N2);
  localparam int unsigned RES_WORDS  = calc_res_words(DEF_M, DEF_N2);
  localparam int unsigned RES_BASE   = LOAD_BYTES;

endpackage

// File: rtl/dmem_loader_packer.sv
// Byte-to-word packer: gathers big-endian bytes and presents a complete 32-bit
// word together with the byte that finishes it.
module dmem_word_packer
  import dmem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] asm_q, asm_d;

  always_comb begin
    lane_d = lane_q;
    asm_d  = asm_q;
    if (clear_i) begin
      lane_d = '0;
    end else if (byte_valid_i) begin
      lane_d = lane_q + 2'd1;
      asm_d  = {asm_q[15:0], byte_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q <= '0;
      asm_q  <= '0;
    end else begin
      lane_q <= lane_d;
      asm_q  <= asm_d;
    end
  end

  // The fourth byte completes the word in the same cycle it is accepted.
  assign word_valid_o = byte_valid_i && (lane_q == LAST_LANE);
  assign word_o       = {asm_q, byte_i};

endmodule

// File: rtl/dmem_loader.sv
// Streams the matrix operands into data memory, optionally zeroes the result
// region (define DMEM_LOADER_CLEAR_EN), then pulses cpu_start once.
module dmem_loader
  import dmem_loader_pkg::*;
#(
  parameter int M      = 3,
  parameter int N      = 4,
  parameter int N2     = 1,
  parameter int ADDR_W = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              go,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              load_done
);

  localparam int unsigned LD_BYTES = calc_load_bytes(M, N, N2);
  localparam logic [ADDR_W-1:0] LAST_BYTE = ADDR_W'(LD_BYTES - 1);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              start_q, start_d;

`ifdef DMEM_LOADER_CLEAR_EN
  localparam int unsigned CLR_WORDS = calc_res_words(M, N2);
  localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(LD_BYTES);
  localparam logic [ADDR_W-1:0] CLR_LAST  = ADDR_W'(LD_BYTES + BYTES_PER_WORD * (CLR_WORDS - 1));
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
`endif

  logic        hs;
  logic        pack_clear;
  logic        word_valid;
  logic [31:0] word;

  assign in_ready   = (state_q == ST_LOAD);
  assign hs         = in_valid && in_ready;
  assign pack_clear = go && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  dmem_word_packer u_packer (
    .clk_i        (CLOCK_50),
    .rst_ni       (reset_n),
    .clear_i      (pack_clear),
    .byte_valid_i (hs),
    .byte_i       (in_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  // Next-state and write-stage logic; the write stage always lags the
  // completing byte by exactly one cycle so loading never has to stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    start_d = 1'b0;
`ifdef DMEM_LOADER_CLEAR_EN
    clr_addr_d = clr_addr_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          cnt_d = cnt_q + ADDR_W'(1);
          if (word_valid) begin
            we_d    = 1'b1;
            addr_d  = {cnt_q[ADDR_W-1:2], 2'b00};
            wdata_d = word;
          end
          if (cnt_q == LAST_BYTE) begin
`ifdef DMEM_LOADER_CLEAR_EN
            state_d    = ST_CLEAR;
            clr_addr_d = CLR_FIRST;
`else
            state_d    = ST_START;
`endif
          end
        end
      end
`ifdef DMEM_LOADER_CLEAR_EN
      ST_CLEAR: begin
        we_d       = 1'b1;
        addr_d     = clr_addr_q;
        wdata_d    = 32'h0;
        clr_addr_d = clr_addr_q + ADDR_W'(BYTES_PER_WORD);
        if (clr_addr_q == CLR_LAST) begin
          state_d = ST_START;
        end
      end
`endif
      ST_START: begin
        start_d = 1'b1;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      start_q <= 1'b0;
`ifdef DMEM_LOADER_CLEAR_EN
      clr_addr_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      start_q <= start_d;
`ifdef DMEM_LOADER_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  // cpu_start is registered so it lands one cycle after the final write.
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_start = start_q;
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CLEAR) || (state_q == ST_START);
  assign load_done = (state_q == ST_DONE);

endmodule
